raster_stream_out: RTL and testbench
====================================

# raster_stream_out

Serializer at the output end of the pixel pipeline. Accepts beats of four horizontally adjacent pixels (raster order, four per beat, matching the four-lane coordinate generator at the pipeline head) and emits one pixel per beat on an AXI4-Stream video interface. Its own raster counters generate start-of-frame (`tuser`) and end-of-line (`tlast`). Sits between the colour-mapping stage and the video DMA.

## Interface
Parameters:
- `PIX_W`, default 24: bits per pixel (RGB888).

Ports:
- `aclk`  in  1: clock.
- `aresetn`  in  1: reset. Synchronous, active-high. Despite the name, 1 = reset.
- `width`  in  16: frame width in pixels. Multiple of 4, range 4..1024.
- `height`  in  16: frame height in lines, range 1..1024.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: input beat accepted when `in_valid && in_ready`.
- `in_pix0`..`in_pix3`  in  PIX_W each: pixels at x, x+1, x+2, x+3.
- `in_x`  in  10: x of `in_pix0`. Used only with `RASTER_CHECK_EN`.
- `in_y`  in  10: line of the beat. Used only with `RASTER_CHECK_EN`.
- `out_tdata`  out  PIX_W: pixel.
- `out_tvalid`  out  1: output valid.
- `out_tready`  in  1: downstream ready.
- `out_tuser`  out  1: high on pixel (0,0) only.
- `out_tlast`  out  1: high on the last pixel of each line.
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame transfers.
- `sync_err`  out  1: sticky raster-mismatch flag.

## Operation
- Holding buffer: 4×PIX_W register, 2-bit sub-index `idx`, `full` flag.
- `in_ready = !full || (out_tvalid && out_tready && idx == 3)`. This allows back-to-back beats with no bubble.
- On input accept: load the buffer, set `idx = 0`, set `full = 1`.
- `out_tvalid = full`. `out_tdata` = buffer[idx].
- Each output handshake:
  - If `idx < 3`: `idx` increments.
  - If `idx == 3`: `full` clears, unless a new beat is accepted in the same cycle.
- Raster counters `x`, `y` (10-bit) give the position of the pixel currently presented.
  - Each output handshake increments `x`.
  - When `x == width-1` (16-bit compare, counter zero-extended): `x` becomes 0 and `y` increments.
  - When additionally `y == height-1`: `y` becomes 0 and `frame_done` pulses the next cycle.
- `out_tuser = full && x == 0 && y == 0`.
- `out_tlast = full && x == width-1`.
- `width`/`height` are latched into internal registers at reset release and on every frame wrap. Changes mid-frame take effect at the next frame.
- While `out_tvalid && !out_tready`, `out_tdata`, `out_tuser` and `out_tlast` hold stable.

## Timing
- Reset values: `in_ready` = 1 (combinational from `full` = 0), `out_tvalid` = 0, `out_tdata` = 0, `out_tuser` = 0, `out_tlast` = 0, `frame_done` = 0, `sync_err` = 0. Also `x = y = idx = 0`.
- Latency: a beat accepted at edge N presents `in_pix0` from cycle N+1.
- Throughput: one input beat per 4 cycles, one pixel per cycle when `out_tready` is held high.
- Reset mid-frame: buffered pixels are discarded and counters return to 0. The next accepted beat is emitted with `tuser` on its first pixel.
- Reset has priority over every concurrent handshake.
- `height == 1`: every line end is also a frame end. `tlast` and wrap occur on the same pixel.

## Configuration
- `RASTER_CHECK_EN` defined:
  - On each input accept, compare `in_x`/`in_y` against the position the beat will occupy. That position is the counters if the buffer is empty, otherwise the counters advanced by the remaining buffered pixels.
  - On mismatch, `sync_err` sets and stays set until reset. Data flow is unaffected.
- `RASTER_CHECK_EN` undefined: `in_x`/`in_y` are ignored, `sync_err` is tied 0, and no compare logic is built.

## Test plan
- Width 8, height 2, `out_tready` = 1, 4 beats of incrementing pixels → 16 output pixels in order. `tuser` on pixel 0 only, `tlast` on pixels 7 and 15, `frame_done` pulse one cycle after pixel 15, zero bubbles.
- Same frame with `out_tready` toggled randomly at 50% → identical output sequence, `tdata`/`tuser`/`tlast` stable during stalls, `in_ready` low while buffer holds un-sent pixels.
- Width 4, height 1, 3 consecutive frames → `tuser` and `tlast` both high on pixels 0, 4, 8 (`tuser`) and pixels 3, 7, 11 (`tlast`). `frame_done` pulses three times.
- Assert `aresetn` = 1 for one cycle after 2 pixels of a beat have been sent → `out_tvalid` = 0 next cycle. The next beat's pixel 0 carries `tuser`.
- With `RASTER_CHECK_EN`: width 8, second beat sent with `in_x` = 0 instead of 4 → `sync_err` = 1 from the cycle after accept and held. Output pixels are unchanged.
- Width changed from 8 to 4 during line 0 of frame 0 → frame 0 completes at width 8. Frame 1 asserts `tlast` every 4 pixels.

Source files
------------

// File: rtl/raster_stream_out.sv
// Four-pixel-beat to one-pixel AXI4-Stream serializer with raster tuser/tlast generation.
// Optional input raster check enabled by defining RASTER_CHECK_EN.
module raster_stream_out #(
  parameter int PIX_W = 24
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix0,
  input  logic [PIX_W-1:0] in_pix1,
  input  logic [PIX_W-1:0] in_pix2,
  input  logic [PIX_W-1:0] in_pix3,
  input  logic [9:0]       in_x,
  input  logic [9:0]       in_y,
  output logic [PIX_W-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tuser,
  output logic             out_tlast,
  output logic             frame_done,
  output logic             sync_err
);

  logic [PIX_W-1:0] r_buf [4];
  logic [1:0]       r_idx;
  logic             r_full;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic [15:0]      r_w;
  logic [15:0]      r_h;
  logic             r_frame_done;

  logic             w_out_hs;
  logic             w_in_acc;
  logic             w_x_end;
  logic             w_y_end;
  logic [9:0]       w_nx;
  logic [9:0]       w_ny;

  assign w_out_hs = r_full && out_tready;
  // Refill is allowed on the same edge the last buffered pixel leaves, so beats stream without a bubble.
  assign in_ready = !r_full || (w_out_hs && (r_idx == 2'd3));
  assign w_in_acc = in_valid && in_ready;
  assign w_x_end  = ({6'd0, r_x} == (r_w - 16'd1));
  assign w_y_end  = ({6'd0, r_y} == (r_h - 16'd1));

  // Raster position following the pixel currently presented.
  always_comb begin
    w_nx = r_x + 10'd1;
    w_ny = r_y;
    if (w_x_end) begin
      w_nx = 10'd0;
      if (w_y_end) begin
        w_ny = 10'd0;
      end else begin
        w_ny = r_y + 10'd1;
      end
    end else begin
      w_ny = r_y;
    end
  end

  // Holding buffer and sub-index.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_idx  <= 2'd0;
      r_full <= 1'b0;
    end else if (w_in_acc) begin
      r_buf[0] <= in_pix0;
      r_buf[1] <= in_pix1;
      r_buf[2] <= in_pix2;
      r_buf[3] <= in_pix3;
      r_idx    <= 2'd0;
      r_full   <= 1'b1;
    end else if (w_out_hs) begin
      if (r_idx == 2'd3) begin
        r_full <= 1'b0;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end else begin
      r_idx  <= r_idx;
      r_full <= r_full;
    end
  end

  // Raster counters; frame geometry is sampled at reset and at each frame wrap.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_w          <= width;
      r_h          <= height;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_hs && w_x_end && w_y_end;
      if (w_out_hs) begin
        r_x <= w_nx;
        r_y <= w_ny;
        if (w_x_end && w_y_end) begin
          r_w <= width;
          r_h <= height;
        end
      end
    end
  end

  assign out_tvalid = r_full;
  assign out_tdata  = r_buf[r_idx];
  assign out_tuser  = r_full && (r_x == 10'd0) && (r_y == 10'd0);
  assign out_tlast  = r_full && w_x_end;
  assign frame_done = r_frame_done;

`ifdef RASTER_CHECK_EN
  logic       r_sync_err;
  logic [9:0] w_exp_x;
  logic [9:0] w_exp_y;

  // A beat accepted while full lands right after the single remaining pixel.
  assign w_exp_x = r_full ? w_nx : r_x;
  assign w_exp_y = r_full ? w_ny : r_y;

  // Sticky raster mismatch flag.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_sync_err <= 1'b0;
    end else if (w_in_acc && ((in_x != w_exp_x) || (in_y != w_exp_y))) begin
      r_sync_err <= 1'b1;
    end else begin
      r_sync_err <= r_sync_err;
    end
  end

  assign sync_err = r_sync_err;
`else
  logic w_unused_raster;
  assign w_unused_raster = &{1'b0, in_x, in_y};
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_raster_stream_out.sv
// Randomized self-checking bench for raster_stream_out against a pixel-queue reference model.
module tb_raster_stream_out;

  typedef struct {
    logic [23:0] p0, p1, p2, p3;
    logic [9:0]  x, y;
    bit          bad;
  } beat_t;

  typedef struct {
    logic [23:0] d;
    bit          u;
    bit          l;
    bit          fend;
  } pix_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [15:0] width = 16'd8;
  logic [15:0] height = 16'd2;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pix0 = 24'd0, in_pix1 = 24'd0, in_pix2 = 24'd0, in_pix3 = 24'd0;
  logic [9:0]  in_x = 10'd0, in_y = 10'd0;
  logic [23:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tuser, out_tlast, frame_done, sync_err;

  beat_t feed[$];
  pix_t  expq[$];
  int    buffered;
  bit    exp_fd;
  bit    exp_sync;
  int    total = 0;
  int    bad = 0;
  int    dut_fd_cnt = 0;
  int    n;
  int    fd0;

  raster_stream_out #(.PIX_W(24)) dut (
    .aclk(aclk), .aresetn(aresetn), .width(width), .height(height),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pix0(in_pix0), .in_pix1(in_pix1), .in_pix2(in_pix2), .in_pix3(in_pix3),
    .in_x(in_x), .in_y(in_y),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tuser(out_tuser), .out_tlast(out_tlast),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame of w*h pixels; beat k covers raster pixels 4k..4k+3. bad_beat gets in_x forced to 0.
  task automatic add_frame(input int w, input int h, input int bad_beat);
    beat_t b;
    pix_t  px;
    for (int k = 0; k < (w * h) / 4; k++) begin
      b.p0 = 24'($urandom); b.p1 = 24'($urandom);
      b.p2 = 24'($urandom); b.p3 = 24'($urandom);
      b.x = 10'((4 * k) % w);
      b.y = 10'((4 * k) / w);
      b.bad = 1'b0;
      if (k == bad_beat) begin
        b.bad = (b.x != 10'd0);
        b.x = 10'd0;
      end
      feed.push_back(b);
      for (int j = 0; j < 4; j++) begin
        int p = 4 * k + j;
        px.d = (j == 0) ? b.p0 : (j == 1) ? b.p1 : (j == 2) ? b.p2 : b.p3;
        px.u = (p == 0);
        px.l = ((p % w) == (w - 1));
        px.fend = (p == (w * h - 1));
        expq.push_back(px);
      end
    end
  endtask

  // One clock: drive at negedge, check, update model, advance to next negedge.
  task automatic cycle(input bit rand_ready);
    beat_t b;
    bit    rdy, exp_rdy, hs;
    rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    out_tready = rdy;
    if (feed.size() > 0) begin
      b = feed[0];
      in_valid = 1'b1;
      in_pix0 = b.p0; in_pix1 = b.p1; in_pix2 = b.p2; in_pix3 = b.p3;
      in_x = b.x; in_y = b.y;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (frame_done === 1'b1) dut_fd_cnt++;
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("sync_err", 32'(sync_err), 32'(exp_sync));
    chk("out_tvalid", 32'(out_tvalid), 32'(buffered > 0));
    exp_rdy = (buffered == 0) || (buffered == 1 && rdy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    exp_fd = 1'b0;
    hs = (buffered > 0) && rdy;
    if (buffered > 0) begin
      chk("tdata", 32'(out_tdata), 32'(expq[0].d));
      chk("tuser", 32'(out_tuser), 32'(expq[0].u));
      chk("tlast", 32'(out_tlast), 32'(expq[0].l));
    end
    if (hs) begin
      exp_fd = expq[0].fend;
      void'(expq.pop_front());
      buffered--;
    end
    if (in_valid && exp_rdy) begin
      void'(feed.pop_front());
      buffered += 4;
`ifdef RASTER_CHECK_EN
      if (b.bad) exp_sync = 1'b1;
`endif
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic run(input bit rand_ready, input int max, output int cycles);
    cycles = 0;
    while (expq.size() > 0 && cycles < max) begin
      cycle(rand_ready);
      cycles++;
    end
    chk("drain_timeout", 32'(expq.size()), 32'd0);
    cycle(rand_ready);
  endtask

  task automatic do_reset(input logic [15:0] w, input logic [15:0] h);
    width = w;
    height = h;
    in_valid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    feed.delete();
    expq.delete();
    buffered = 0;
    exp_fd = 1'b0;
    exp_sync = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_tdata", 32'(out_tdata), 32'd0);
    chk("rst_tuser", 32'(out_tuser), 32'd0);
    chk("rst_tlast", 32'(out_tlast), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
  endtask

  initial begin
    @(negedge aclk);

    // Full-rate 8x2 frame: first beat accepted in cycle 0, 16 pixels follow without a gap.
    do_reset(16'd8, 16'd2);
    fd0 = dut_fd_cnt;
    add_frame(8, 2, -1);
    run(1'b0, 200, n);
    chk("t1_cycles", 32'(n), 32'd17);
    chk("t1_fd_count", 32'(dut_fd_cnt - fd0), 32'd1);

    // Same frame with random backpressure.
    do_reset(16'd8, 16'd2);
    fd0 = dut_fd_cnt;
    add_frame(8, 2, -1);
    run(1'b1, 500, n);
    chk("t2_fd_count", 32'(dut_fd_cnt - fd0), 32'd1);

    // Height 1: three 4-pixel frames back to back.
    do_reset(16'd4, 16'd1);
    fd0 = dut_fd_cnt;
    add_frame(4, 1, -1);
    add_frame(4, 1, -1);
    add_frame(4, 1, -1);
    run(1'b0, 200, n);
    chk("t3_fd_count", 32'(dut_fd_cnt - fd0), 32'd3);

    // Reset after two pixels of a beat, with a beat still offered during reset.
    do_reset(16'd8, 16'd2);
    add_frame(8, 2, -1);
    n = 0;
    while (expq.size() > 14 && n < 50) begin
      cycle(1'b0);
      n++;
    end
    chk("t4_sent2", 32'(expq.size()), 32'd14);
    aresetn = 1'b1;
    in_valid = 1'b1;
    out_tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t4_tvalid_after_rst", 32'(out_tvalid), 32'd0);
    chk("t4_in_ready_after_rst", 32'(in_ready), 32'd1);
    feed.delete();
    expq.delete();
    buffered = 0;
    exp_fd = 1'b0;
    exp_sync = 1'b0;
    add_frame(8, 2, -1);
    run(1'b1, 500, n);

    // Wrong in_x on the second beat: sticky sync_err only when the check is built.
    do_reset(16'd8, 16'd1);
    add_frame(8, 1, 1);
    add_frame(8, 1, -1);
    run(1'b1, 500, n);
    cycle(1'b0);

    // Width changed mid-frame: frame 0 stays at 8, frame 1 uses 4.
    do_reset(16'd8, 16'd2);
    fd0 = dut_fd_cnt;
    add_frame(8, 2, -1);
    add_frame(4, 2, -1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    width = 16'd4;
    run(1'b1, 500, n);
    chk("t6_fd_count", 32'(dut_fd_cnt - fd0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
